// File: rtl/fp_pkg.sv
// Shared single-precision float types and constants for the FP datapath.
package fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    localparam int          FP_BIAS     = 127;
    localparam logic [7:0]  FP_EXP_I32  = 8'(FP_BIAS + 31);
    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

endpackage

// File: rtl/i2f_pipe_lzc32.sv
// Combinational 32-bit leading-zero counter with an all-zero flag.
module lzc32 (
    input  logic [31:0] x,
    output logic [4:0]  cnt,
    output logic        all_zero
);

    // Ascending scan: the highest set bit is the last one to write cnt.
    always_comb begin
        cnt = 5'd31;
        for (int i = 0; i < 32; i++) begin
            if (x[i]) cnt = 5'(31 - i);
        end
    end

    assign all_zero = ~|x;

endmodule

// File: rtl/i2f_pipe.sv
// Three-stage signed int32 to IEEE-754 single converter with valid/ready
// handshake on both sides and an inexact (precision lost) flag.
module i2f_pipe
    import fp_pkg::*;
#(
    parameter bit RND = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] d,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] a,
    output logic        p_lost
);

    logic v1, v2, v3;
    logic en1, en2, en3;

    logic        s1_sign;
    logic [31:0] s1_mag;

    logic        s2_sign;
    logic        s2_zero;
    logic [31:0] s2_m;
    logic [7:0]  s2_exp;

    fp32_t s3_res;
    logic  s3_lost;

    logic [4:0] lz_cnt;
    logic       lz_zero;

    fp32_t      rnd_res;
    logic       rnd_lost;
    logic       g_bit;
    logic       s_bit;
    logic       inc;
    logic [23:0] frac_sum;

    assign en3      = ~v3 | out_ready;
    assign en2      = ~v2 | en3;
    assign en1      = ~v1 | en2;
    assign in_ready = en1;

    lzc32 u_lzc (
        .x        (s1_mag),
        .cnt      (lz_cnt),
        .all_zero (lz_zero)
    );

    always_comb begin
        g_bit    = s2_m[7];
        s_bit    = |s2_m[6:0];
        inc      = (RND == 1'b0) ? (g_bit & (s_bit | s2_m[8])) : 1'b0;
        frac_sum = {1'b0, s2_m[30:8]} + {23'd0, inc};
        rnd_res  = fp32_t'(FP_POS_ZERO);
        rnd_lost = 1'b0;
        if (!s2_zero) begin
            rnd_res.sign = s2_sign;
            // A carry out of the fraction leaves frac_sum[22:0] all zero.
            rnd_res.exp  = s2_exp + {7'd0, frac_sum[23]};
            rnd_res.frac = frac_sum[22:0];
            rnd_lost     = g_bit | s_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            s3_res  <= fp32_t'(FP_POS_ZERO);
            s3_lost <= 1'b0;
        end else begin
            if (en1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    s1_sign <= d[31];
                    s1_mag  <= d[31] ? (~d + 32'd1) : d;
                end
            end
            if (en2) begin
                v2 <= v1;
                if (v1) begin
                    s2_sign <= s1_sign;
                    s2_zero <= lz_zero;
                    s2_m    <= s1_mag << lz_cnt;
                    s2_exp  <= FP_EXP_I32 - {3'd0, lz_cnt};
                end
            end
            if (en3) begin
                v3 <= v2;
                if (v2) begin
                    s3_res  <= rnd_res;
                    s3_lost <= rnd_lost;
                end
            end
        end
    end

    assign out_valid = v3;
    assign a         = s3_res;
    assign p_lost    = s3_lost;

endmodule

// File: tb/tb_i2f_pipe.sv
// Directed bench for i2f_pipe: one instance per rounding mode, shared stimulus.
module tb_i2f_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] d;
    logic        out_ready;
    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [31:0] a0, a1;
    logic        p_lost0, p_lost1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    i2f_pipe #(.RND(1'b0)) dut_rne (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .d(d),
        .out_valid(out_valid0), .out_ready(out_ready), .a(a0), .p_lost(p_lost0)
    );

    i2f_pipe #(.RND(1'b1)) dut_rtz (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .d(d),
        .out_valid(out_valid1), .out_ready(out_ready), .a(a1), .p_lost(p_lost1)
    );

    typedef struct {
        logic [31:0] d;
        logic [31:0] a_rne;
        logic        p_rne;
        logic [31:0] a_rtz;
        logic        p_rtz;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Sends one operand and checks latency and results on both instances.
    task automatic send_one(input string name, input vec_t v);
        int lat;
        @(negedge clk);
        d        = v.d;
        in_valid = 1'b1;
        chk({name, " in_ready"}, {31'd0, in_ready0}, 32'd1);
        @(posedge clk);
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            if (out_valid0) break;
        end
        chk({name, " latency"}, lat, 3);
        chk({name, " valid_rtz"}, {31'd0, out_valid1}, 32'd1);
        chk({name, " a_rne"}, a0, v.a_rne);
        chk({name, " p_rne"}, {31'd0, p_lost0}, {31'd0, v.p_rne});
        chk({name, " a_rtz"}, a1, v.a_rtz);
        chk({name, " p_rtz"}, {31'd0, p_lost1}, {31'd0, v.p_rtz});
    endtask

    vec_t vecs[12];
    logic [31:0] bp_exp[8];

    initial begin
        vec_t v5;
        logic [31:0] held;
        logic        holding;
        int          sent, rcvd, cyc;

        vecs[0]  = '{32'd1,        32'h3F80_0000, 1'b0, 32'h3F80_0000, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 32'hBF80_0000, 1'b0};
        vecs[2]  = '{32'd0,        32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vecs[3]  = '{32'h8000_0000, 32'hCF00_0000, 1'b0, 32'hCF00_0000, 1'b0};
        vecs[4]  = '{32'h7FFF_FFFF, 32'h4F00_0000, 1'b1, 32'h4EFF_FFFF, 1'b1};
        vecs[5]  = '{32'd16777217, 32'h4B80_0000, 1'b1, 32'h4B80_0000, 1'b1};
        vecs[6]  = '{32'd16777219, 32'h4B80_0002, 1'b1, 32'h4B80_0001, 1'b1};
        vecs[7]  = '{32'd16777218, 32'h4B80_0001, 1'b0, 32'h4B80_0001, 1'b0};
        vecs[8]  = '{32'd100,      32'h42C8_0000, 1'b0, 32'h42C8_0000, 1'b0};
        vecs[9]  = '{32'hFFFF_FFFE, 32'hC000_0000, 1'b0, 32'hC000_0000, 1'b0};
        vecs[10] = '{32'hFEFF_FFFD, 32'hCB80_0002, 1'b1, 32'hCB80_0001, 1'b1};
        vecs[11] = '{32'd16777216, 32'h4B80_0000, 1'b0, 32'h4B80_0000, 1'b0};
        bp_exp   = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                     32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
        v5       = '{32'd5, 32'h40A0_0000, 1'b0, 32'h40A0_0000, 1'b0};

        rst = 1'b1; in_valid = 1'b0; d = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst out_valid", {31'd0, out_valid0}, 32'd0);
        chk("rst a", a0, 32'd0);
        chk("rst p_lost", {31'd0, p_lost0}, 32'd0);
        chk("rst in_ready", {31'd0, in_ready0}, 32'd1);

        for (int i = 0; i < 12; i++) send_one($sformatf("vec%0d", i), vecs[i]);

        // Backpressure: 8 back-to-back operands, out_ready low for cycles 4..8.
        @(negedge clk);
        sent = 0; rcvd = 0; holding = 1'b0; held = '0;
        for (cyc = 0; cyc < 60 && rcvd < 8; cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 8);
            in_valid  = (sent < 8);
            d         = 32'(sent + 1);
            #1;
            if (cyc == 5) chk("bp in_ready low", {31'd0, in_ready0}, 32'd0);
            if (holding) begin
                chk("bp stall valid", {31'd0, out_valid0}, 32'd1);
                chk("bp stall a", a0, held);
            end
            holding = out_valid0 & ~out_ready;
            held    = a0;
            if (out_valid0 && out_ready) begin
                chk($sformatf("bp res%0d", rcvd), a0, bp_exp[rcvd]);
                rcvd++;
            end
            if (in_valid && in_ready0) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp received", rcvd, 8);
        repeat (3) @(negedge clk);
        chk("bp no extra", {31'd0, out_valid0}, 32'd0);

        // Reset with three operands held in the pipe.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; d = 32'(i + 40);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("pre-rst full", {31'd0, out_valid0}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid-rst out_valid", {31'd0, out_valid0}, 32'd0);
        chk("mid-rst in_ready", {31'd0, in_ready0}, 32'd1);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        begin
            int stale = 0;
            repeat (6) begin
                @(negedge clk);
                if (out_valid0 || out_valid1) stale++;
            end
            chk("post-rst stale", stale, 0);
        end
        send_one("post-rst d5", v5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
